// File: rtl/recovery_phase_sequencer.sv
// Recovery phase sequencer: COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT after an accepted recovery.
// Optional statistics counters are built when RSD_RECOVERY_SEQ_STATS_EN is defined.
module recovery_phase_sequencer #(
  parameter int COMMIT_WIDTH          = 2,
  parameter int ACTIVE_LIST_ENTRY_NUM = 64,
  parameter int REFETCH_TYPE_WIDTH    = 3,
  parameter int EXEC_STATE_WIDTH      = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cm_exception_valid,
  input  logic [REFETCH_TYPE_WIDTH-1:0]            cm_refetch_type,
  input  logic [$clog2(COMMIT_WIDTH)-1:0]          cm_recovery_op_index,
  input  logic [EXEC_STATE_WIDTH-1:0]              cm_recovery_cause,
  input  logic                                     be_exception_valid,
  input  logic [REFETCH_TYPE_WIDTH-1:0]            be_refetch_type,
  input  logic [$clog2(ACTIVE_LIST_ENTRY_NUM):0]   flush_entry_num,
  input  logic                                     store_commit_busy,
  output logic [1:0]                               phase,
  output logic                                     unable_to_start_recovery,
  output logic                                     recovery_start,
  output logic                                     recovery_from_commit,
  output logic [REFETCH_TYPE_WIDTH-1:0]            refetch_type,
  output logic [$clog2(COMMIT_WIDTH)-1:0]          recovery_op_index,
  output logic [EXEC_STATE_WIDTH-1:0]              recovery_cause,
  output logic                                     rename_logic_recovery_rmt,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]        flush_num,
  output logic                                     recovery_done,
  output logic [31:0]                              stat_cm_count,
  output logic [31:0]                              stat_be_count
);

  localparam int IDX_W = $clog2(COMMIT_WIDTH);
  localparam int REM_W = $clog2(ACTIVE_LIST_ENTRY_NUM) + 1;
  localparam int FN_W  = $clog2(COMMIT_WIDTH + 1);
  localparam logic [REM_W-1:0] CW_REM    = REM_W'(COMMIT_WIDTH);
  localparam logic [REM_W-1:0] AL_REM    = REM_W'(ACTIVE_LIST_ENTRY_NUM);
  localparam logic [FN_W-1:0]  CW_FLUSH  = FN_W'(COMMIT_WIDTH);

  typedef enum logic [1:0] {
    PH_COMMIT    = 2'd0,
    PH_RECOVER_0 = 2'd1,
    PH_RECOVER_1 = 2'd2
  } phase_e;

  phase_e                        phase_q, phase_d;
  logic [REM_W-1:0]              remaining_q, remaining_d;
  logic                          from_commit_q, from_commit_d;
  logic [REFETCH_TYPE_WIDTH-1:0] refetch_type_q, refetch_type_d;
  logic [IDX_W-1:0]              op_index_q, op_index_d;
  logic [EXEC_STATE_WIDTH-1:0]   cause_q, cause_d;

  logic                          accept_s;
  logic                          last_s;
  logic [REM_W-1:0]              flush_sat_s;
  logic [FN_W-1:0]               flush_now_s;

  // Accept decode, saturated flush count and per-cycle flush amount from registered state.
  always_comb begin
    accept_s    = (phase_q == PH_COMMIT) && !store_commit_busy &&
                  (cm_exception_valid || be_exception_valid);
    flush_sat_s = (flush_entry_num > AL_REM) ? AL_REM : flush_entry_num;
    if (phase_q == PH_RECOVER_1) begin
      flush_now_s = (remaining_q > CW_REM) ? CW_FLUSH : FN_W'(remaining_q);
      last_s      = (remaining_q <= CW_REM);
    end else begin
      flush_now_s = '0;
      last_s      = 1'b0;
    end
  end

  // Next-state and latched-field logic; the commit request wins when both are valid.
  always_comb begin
    phase_d        = phase_q;
    remaining_d    = remaining_q;
    from_commit_d  = from_commit_q;
    refetch_type_d = refetch_type_q;
    op_index_d     = op_index_q;
    cause_d        = cause_q;
    case (phase_q)
      PH_COMMIT: begin
        if (accept_s) begin
          phase_d     = PH_RECOVER_0;
          remaining_d = flush_sat_s;
          if (cm_exception_valid) begin
            from_commit_d  = 1'b1;
            refetch_type_d = cm_refetch_type;
            op_index_d     = cm_recovery_op_index;
            cause_d        = cm_recovery_cause;
          end else begin
            from_commit_d  = 1'b0;
            refetch_type_d = be_refetch_type;
            op_index_d     = '0;
            cause_d        = '0;
          end
        end else begin
          phase_d = PH_COMMIT;
        end
      end
      PH_RECOVER_0: phase_d = PH_RECOVER_1;
      PH_RECOVER_1: begin
        remaining_d = remaining_q - REM_W'(flush_now_s);
        if (last_s) begin
          phase_d = PH_COMMIT;
        end else begin
          phase_d = PH_RECOVER_1;
        end
      end
      default: begin
        phase_d     = PH_COMMIT;
        remaining_d = '0;
      end
    endcase
  end

  // State and latched-field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= PH_COMMIT;
      remaining_q    <= '0;
      from_commit_q  <= 1'b0;
      refetch_type_q <= '0;
      op_index_q     <= '0;
      cause_q        <= '0;
    end else begin
      phase_q        <= phase_d;
      remaining_q    <= remaining_d;
      from_commit_q  <= from_commit_d;
      refetch_type_q <= refetch_type_d;
      op_index_q     <= op_index_d;
      cause_q        <= cause_d;
    end
  end

  assign phase                     = phase_q;
  assign unable_to_start_recovery  = (phase_q != PH_COMMIT) || store_commit_busy;
  assign recovery_start            = accept_s;
  assign recovery_from_commit      = from_commit_q;
  assign refetch_type              = refetch_type_q;
  assign recovery_op_index         = op_index_q;
  assign recovery_cause            = cause_q;
  assign rename_logic_recovery_rmt = (phase_q == PH_RECOVER_1);
  assign flush_num                 = flush_now_s;
  assign recovery_done             = last_s;

`ifdef RSD_RECOVERY_SEQ_STATS_EN
  logic [31:0] stat_cm_q, stat_cm_d;
  logic [31:0] stat_be_q, stat_be_d;

  // Saturating per-source accept counters.
  always_comb begin
    stat_cm_d = stat_cm_q;
    stat_be_d = stat_be_q;
    if (accept_s && cm_exception_valid) begin
      if (stat_cm_q != 32'hFFFF_FFFF) begin
        stat_cm_d = stat_cm_q + 32'd1;
      end else begin
        stat_cm_d = stat_cm_q;
      end
    end else if (accept_s) begin
      if (stat_be_q != 32'hFFFF_FFFF) begin
        stat_be_d = stat_be_q + 32'd1;
      end else begin
        stat_be_d = stat_be_q;
      end
    end else begin
      stat_cm_d = stat_cm_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cm_q <= 32'd0;
      stat_be_q <= 32'd0;
    end else begin
      stat_cm_q <= stat_cm_d;
      stat_be_q <= stat_be_d;
    end
  end

  assign stat_cm_count = stat_cm_q;
  assign stat_be_count = stat_be_q;
`else
  assign stat_cm_count = 32'd0;
  assign stat_be_count = 32'd0;
`endif

endmodule

// File: tb/tb_recovery_phase_sequencer.sv
// Table-driven scoreboard bench for recovery_phase_sequencer plus a saturation sequence.
module tb_recovery_phase_sequencer;

`ifdef RSD_RECOVERY_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cm_exception_valid = 1'b0;
  logic [2:0]  cm_refetch_type = 3'd0;
  logic [0:0]  cm_recovery_op_index = 1'b0;
  logic [3:0]  cm_recovery_cause = 4'd0;
  logic        be_exception_valid = 1'b0;
  logic [2:0]  be_refetch_type = 3'd0;
  logic [6:0]  flush_entry_num = 7'd0;
  logic        store_commit_busy = 1'b0;
  logic [1:0]  phase;
  logic        unable_to_start_recovery, recovery_start, recovery_from_commit;
  logic [2:0]  refetch_type;
  logic [0:0]  recovery_op_index;
  logic [3:0]  recovery_cause;
  logic        rename_logic_recovery_rmt;
  logic [1:0]  flush_num;
  logic        recovery_done;
  logic [31:0] stat_cm_count, stat_be_count;

  recovery_phase_sequencer dut (
    .clk(clk), .rst(rst),
    .cm_exception_valid(cm_exception_valid), .cm_refetch_type(cm_refetch_type),
    .cm_recovery_op_index(cm_recovery_op_index), .cm_recovery_cause(cm_recovery_cause),
    .be_exception_valid(be_exception_valid), .be_refetch_type(be_refetch_type),
    .flush_entry_num(flush_entry_num), .store_commit_busy(store_commit_busy),
    .phase(phase), .unable_to_start_recovery(unable_to_start_recovery),
    .recovery_start(recovery_start), .recovery_from_commit(recovery_from_commit),
    .refetch_type(refetch_type), .recovery_op_index(recovery_op_index),
    .recovery_cause(recovery_cause), .rename_logic_recovery_rmt(rename_logic_recovery_rmt),
    .flush_num(flush_num), .recovery_done(recovery_done),
    .stat_cm_count(stat_cm_count), .stat_be_count(stat_be_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, cmv, cmt, cmi, cmc, bev, bet, fl, busy;
    int ph, un, st, dn, fn, fc, rt, ri, rc, scm, sbe;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic add(input int rs, cmv, cmt, cmi, cmc, bev, bet, fl, busy,
                     input int ph, un, st, dn, fn, fc, rt, ri, rc, scm, sbe);
    vec_t v;
    v.rst = rs; v.cmv = cmv; v.cmt = cmt; v.cmi = cmi; v.cmc = cmc;
    v.bev = bev; v.bet = bet; v.fl = fl; v.busy = busy;
    v.ph = ph; v.un = un; v.st = st; v.dn = dn; v.fn = fn;
    v.fc = fc; v.rt = rt; v.ri = ri; v.rc = rc; v.scm = scm; v.sbe = sbe;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst                  = v.rst[0];
    cm_exception_valid   = v.cmv[0];
    cm_refetch_type      = v.cmt[2:0];
    cm_recovery_op_index = v.cmi[0:0];
    cm_recovery_cause    = v.cmc[3:0];
    be_exception_valid   = v.bev[0];
    be_refetch_type      = v.bet[2:0];
    flush_entry_num      = v.fl[6:0];
    store_commit_busy    = v.busy[0];
  endtask

  task automatic compare(input vec_t e, input int i);
    chk("phase", i, phase, e.ph);
    chk("unable", i, unable_to_start_recovery, e.un);
    chk("start", i, recovery_start, e.st);
    chk("done", i, recovery_done, e.dn);
    chk("flush_num", i, flush_num, e.fn);
    chk("rmt", i, rename_logic_recovery_rmt, (e.ph == 2) ? 1 : 0);
    chk("from_commit", i, recovery_from_commit, e.fc);
    chk("refetch_type", i, refetch_type, e.rt);
    chk("op_index", i, recovery_op_index, e.ri);
    chk("cause", i, recovery_cause, e.rc);
    chk("stat_cm", i, stat_cm_count, STATS ? e.scm : 0);
    chk("stat_be", i, stat_be_count, STATS ? e.sbe : 0);
  endtask

  initial begin
    vec_t cur;
    int r1, sum, dn;
    bit back;
    //  rst cmv cmt cmi cmc bev bet fl busy | ph un st dn fn fc rt ri rc scm sbe
    add(1, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,0,0, 0,0);  // reset
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,0,0, 0,0);
    add(0, 1,3,1,5, 0,0, 5,0,   0,0,1,0,0, 0,0,0,0, 0,0);  // commit, flush 5
    add(0, 0,0,0,0, 0,0, 0,0,   1,1,0,0,0, 1,3,1,5, 1,0);
    add(0, 1,7,0,9, 1,1, 3,0,   2,1,0,0,2, 1,3,1,5, 1,0);  // ignored request
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,0,2, 1,3,1,5, 1,0);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,1,1, 1,3,1,5, 1,0);
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 1,3,1,5, 1,0);
    add(0, 1,4,0,2, 1,2, 2,0,   0,0,1,0,0, 1,3,1,5, 1,0);  // both valid
    add(0, 0,0,0,0, 0,0, 0,0,   1,1,0,0,0, 1,4,0,2, 2,0);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,1,2, 1,4,0,2, 2,0);
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 1,4,0,2, 2,0);
    add(0, 1,1,1,9, 0,0, 3,1,   0,1,0,0,0, 1,4,0,2, 2,0);  // busy blocks
    add(0, 1,1,1,9, 0,0, 3,0,   0,0,1,0,0, 1,4,0,2, 2,0);  // busy drops
    add(0, 0,0,0,0, 0,0, 0,0,   1,1,0,0,0, 1,1,1,9, 3,0);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,0,2, 1,1,1,9, 3,0);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,1,1, 1,1,1,9, 3,0);
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 1,1,1,9, 3,0);
    add(0, 0,0,1,7, 1,6, 0,0,   0,0,1,0,0, 1,1,1,9, 3,0);  // backend, flush 0
    add(0, 0,0,0,0, 0,0, 0,0,   1,1,0,0,0, 0,6,0,0, 3,1);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,1,0, 0,6,0,0, 3,1);
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,6,0,0, 3,1);
    add(0, 1,5,0,3, 0,0, 8,0,   0,0,1,0,0, 0,6,0,0, 3,1);  // flush 8
    add(0, 0,0,0,0, 0,0, 0,0,   1,1,0,0,0, 1,5,0,3, 4,1);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,0,2, 1,5,0,3, 4,1);
    add(1, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,0,0, 0,0);  // reset mid-flush
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,0,0, 0,0);
    add(0, 1,2,1,1, 0,0, 1,0,   0,0,1,0,0, 0,0,0,0, 0,0);
    add(0, 0,0,0,0, 0,0, 0,0,   1,1,0,0,0, 1,2,1,1, 1,0);
    add(0, 0,0,0,0, 0,0, 0,0,   2,1,0,1,1, 1,2,1,1, 1,0);
    add(0, 0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 1,2,1,1, 1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(posedge clk);
      #1;
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      #3;
      cur = sb.pop_front();
      compare(cur, i);
    end

    // Oversized flush count saturates to the active-list depth: 32 cycles of 2.
    @(posedge clk); #1;
    be_exception_valid = 1'b1; be_refetch_type = 3'd1; flush_entry_num = 7'd100;
    #3;
    chk("sat_start", 100, recovery_start, 1);
    @(posedge clk); #1;
    be_exception_valid = 1'b0; flush_entry_num = 7'd0;
    #3;
    chk("sat_r0", 100, phase, 1);
    r1 = 0; sum = 0; dn = 0; back = 1'b0;
    for (int k = 0; k < 100 && !back; k++) begin
      @(posedge clk); #4;
      if (phase == 2'd2) begin
        r1++; sum += flush_num; dn += recovery_done;
      end else if (phase == 2'd0) begin
        back = 1'b1;
      end else begin
        r1 = r1;
      end
    end
    chk("sat_returned", 100, back, 1);
    chk("sat_r1_cycles", 100, r1, 32);
    chk("sat_flush_sum", 100, sum, 64);
    chk("sat_done_pulses", 100, dn, 1);
    chk("sat_from_commit", 100, recovery_from_commit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recovery_phase_sequencer.md
# recovery_phase_sequencer

Sequences the processor's recovery phases after a commit-stage exception or backend misprediction is accepted. Sits directly downstream of the commit stage: consumes its recovery request, refetch type, lane index and cause, and drives the pipeline phase, the unable-to-start-recovery back-pressure, RMT-restore enable and per-cycle active-list flush counts. Returns the pipeline to the commit phase when the flush walk finishes.

## Interface

Parameters:
- COMMIT_WIDTH, 2: commit lanes; also the maximum number of entries flushed per cycle.
- ACTIVE_LIST_ENTRY_NUM, 64: active-list depth.
- REFETCH_TYPE_WIDTH, 3: refetch-type encoding width.
- EXEC_STATE_WIDTH, 4: execution-state encoding width.

Ports (clock is `clk`, reset is `rst`, one clock, asynchronous active-high reset):
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- cm_exception_valid  in  1  commit stage requests recovery.
- cm_refetch_type  in  REFETCH_TYPE_WIDTH  refetch type from commit.
- cm_recovery_op_index  in  $clog2(COMMIT_WIDTH)  lane of the triggering op.
- cm_recovery_cause  in  EXEC_STATE_WIDTH  execution state causing recovery.
- be_exception_valid  in  1  backend branch misprediction request.
- be_refetch_type  in  REFETCH_TYPE_WIDTH  refetch type from backend.
- flush_entry_num  in  $clog2(ACTIVE_LIST_ENTRY_NUM)+1  entries to squash; qualified by the accepted request.
- store_commit_busy  in  1  store drain in flight; recovery may not start.
- phase  out  2  0 = COMMIT, 1 = RECOVER_0, 2 = RECOVER_1.
- unable_to_start_recovery  out  1  back-pressure to the commit stage.
- recovery_start  out  1  one-cycle pulse when a request is accepted.
- recovery_from_commit  out  1  latched: 1 if the commit stage is the source, 0 if the backend is.
- refetch_type  out  REFETCH_TYPE_WIDTH  latched refetch type.
- recovery_op_index  out  $clog2(COMMIT_WIDTH)  latched lane; 0 for backend requests.
- recovery_cause  out  EXEC_STATE_WIDTH  latched cause; 0 for backend requests.
- rename_logic_recovery_rmt  out  1  high throughout RECOVER_1.
- flush_num  out  $clog2(COMMIT_WIDTH+1)  entries flushed this cycle.
- recovery_done  out  1  pulse on the last RECOVER_1 cycle.
- stat_cm_count  out  32  commit-sourced recoveries (see Configuration).
- stat_be_count  out  32  backend-sourced recoveries (see Configuration).

## Operation

- State machine: COMMIT → RECOVER_0 → RECOVER_1 → COMMIT.
- unable_to_start_recovery is combinational: `(phase != COMMIT) || store_commit_busy`.
- Accept condition: phase == COMMIT, !store_commit_busy, and either valid request.
  - If both requests are valid, the commit request wins (it is older).
  - The backend request is dropped; no queueing.
- On accept:
  - Latch type, index, cause and source.
  - Load remaining = flush_entry_num.
  - Pulse recovery_start.
- Requests arriving in any other phase, or while busy, are ignored.
- RECOVER_0 lasts exactly one cycle; flush_num = 0 in this state.
- RECOVER_1, each cycle:
  - flush_num = min(remaining, COMMIT_WIDTH).
  - remaining -= flush_num.
  - When remaining ≤ COMMIT_WIDTH at cycle start, this is the last cycle: assert recovery_done, next phase COMMIT.
  - If remaining = 0, RECOVER_1 still lasts one cycle with flush_num = 0.
- Latched outputs hold their values until the next accept.
- flush_entry_num > ACTIVE_LIST_ENTRY_NUM saturates to ACTIVE_LIST_ENTRY_NUM.

## Timing

- Reset values: phase = 0, all latched fields 0, remaining = 0, all pulses 0, stat counters 0.
- Reset is effective immediately, including mid-recovery; no flush continues after reset.
- Request sampled at edge t:
  - recovery_start is high in cycle t (combinational from the accept condition).
  - phase = RECOVER_0 in cycle t+1.
  - phase = RECOVER_1 in cycles t+2 … t+1+max(1, ⌈N/COMMIT_WIDTH⌉).
  - phase = COMMIT on the following cycle.
- A new request can be accepted in the first COMMIT cycle after recovery_done.
- rename_logic_recovery_rmt and flush_num are registered-state decodes: no input-to-output combinational path.

## Configuration

- RSD_RECOVERY_SEQ_STATS_EN defined:
  - stat_cm_count increments on each commit-sourced accept.
  - stat_be_count increments on each backend-sourced accept.
  - Both counters saturate at 0xFFFF_FFFF.
- Not defined: counters are not built; both outputs are tied to 0.

## Test plan

- Reset with all inputs at 0 → phase = 0, unable = 0, flush_num = 0, recovery_done = 0.
- Commit request with refetch = 3, index = 1, cause = 5, flush = 5 → RECOVER_0 at t+1; RECOVER_1 at t+2..t+4 with flush_num 2, 2, 1; recovery_done at t+4; COMMIT at t+5; latched outputs 3/1/5.
- Commit and backend requests in the same cycle (backend refetch = 2) → recovery_from_commit = 1, refetch_type = commit value, stat_cm_count = 1, stat_be_count = 0.
- store_commit_busy = 1 with commit request → unable = 1, phase stays 0, no recovery_start; busy drops next cycle with request still high → accepted then.
- Backend request with flush = 0 → RECOVER_1 for one cycle with flush_num = 0 and recovery_done = 1; recovery_op_index = 0, recovery_cause = 0.
- rst asserted in the second RECOVER_1 cycle of a flush = 8 recovery → phase = 0 and flush_num = 0 immediately; first post-reset request is handled normally.
